// File: rtl/cmp_wb_buffer.sv
// Writeback buffer for the compare FU: a small FIFO of {rob_index, result}
// entries feeding the ROB/regfile writeback port through a valid/ready handshake.
module cmp_wb_buffer #(
    parameter int ROB_INDEX_WIDTH = 4,
    parameter int DEPTH           = 4,
    parameter int XLEN            = 64
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush_i,
    input  logic                       fu_done_i,
    input  logic [ROB_INDEX_WIDTH-1:0] fu_rob_index_i,
    input  logic                       fu_result_i,
    output logic                       fu_stall_o,
    output logic                       wb_valid_o,
    input  logic                       wb_ready_i,
    output logic [ROB_INDEX_WIDTH-1:0] wb_rob_index_o,
    output logic [XLEN-1:0]            wb_data_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              count_q,  count_d;
    logic [ROB_INDEX_WIDTH-1:0] idx_mem_q [DEPTH];
    logic [ROB_INDEX_WIDTH-1:0] idx_mem_d [DEPTH];
    logic                       res_mem_q [DEPTH];
    logic                       res_mem_d [DEPTH];

    logic fire_in;
    logic fire_out;

    // Stall depends only on the registered count, so a same-cycle dequeue never frees a slot.
    assign fu_stall_o = (count_q == CW'(DEPTH));
    assign wb_valid_o = (count_q != '0);
    assign count_o    = count_q;

    assign fire_in  = fu_done_i && !fu_stall_o && !flush_i;
    assign fire_out = wb_valid_o && wb_ready_i && !flush_i;

    // Head outputs read as zero while empty so reset and flush present a clean port.
    assign wb_rob_index_o = wb_valid_o ? idx_mem_q[rd_ptr_q] : '0;
    assign wb_data_o      = {{(XLEN-1){1'b0}}, wb_valid_o & res_mem_q[rd_ptr_q]};

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        idx_mem_d = idx_mem_q;
        res_mem_d = res_mem_q;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (fire_in) begin
                idx_mem_d[wr_ptr_q] = fu_rob_index_i;
                res_mem_d[wr_ptr_q] = fu_result_i;
                wr_ptr_d            = wr_ptr_q + PW'(1);
            end
            if (fire_out) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (fire_in && !fire_out) begin
                count_d = count_q + CW'(1);
            end else if (!fire_in && fire_out) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage carries no reset; stale contents are never visible while empty.
    always_ff @(posedge clk) begin
        idx_mem_q <= idx_mem_d;
        res_mem_q <= res_mem_d;
    end

endmodule

// File: tb/tb_cmp_wb_buffer.sv
// Self-checking bench for cmp_wb_buffer: table of per-cycle vectors with
// expected status, plus a scoreboard queue checking retired entries in order.
module tb_cmp_wb_buffer;

    localparam int RIW   = 4;
    localparam int DEPTH = 4;
    localparam int XLEN  = 64;

    logic            clk;
    logic            rstn;
    logic            flushIn;
    logic            fuDone;
    logic [RIW-1:0]  fuRobIndex;
    logic            fuResult;
    logic            fuStall;
    logic            wbValid;
    logic            wbReady;
    logic [RIW-1:0]  wbRobIndex;
    logic [XLEN-1:0] wbData;
    logic [$clog2(DEPTH):0] countOut;

    cmp_wb_buffer #(
        .ROB_INDEX_WIDTH(RIW),
        .DEPTH(DEPTH),
        .XLEN(XLEN)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .flush_i(flushIn),
        .fu_done_i(fuDone),
        .fu_rob_index_i(fuRobIndex),
        .fu_result_i(fuResult),
        .fu_stall_o(fuStall),
        .wb_valid_o(wbValid),
        .wb_ready_i(wbReady),
        .wb_rob_index_o(wbRobIndex),
        .wb_data_o(wbData),
        .count_o(countOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic           rs;
        logic           flush;
        logic           done;
        logic [RIW-1:0] idx;
        logic           res;
        logic           ready;
        int             expCount;
        logic           expStall;
        logic           expValid;
    } step_t;

    typedef struct packed {
        logic [RIW-1:0] idx;
        logic           res;
    } sbItem_t;

    step_t   steps[$];
    sbItem_t sbQ[$];
    int      checks = 0;
    int      failures = 0;

    function automatic step_t mk(input logic rs, input logic fl, input logic dn,
                                 input logic [RIW-1:0] ix, input logic rz, input logic rd,
                                 input int ec, input logic es, input logic ev);
        step_t s;
        s.rs = rs; s.flush = fl; s.done = dn; s.idx = ix; s.res = rz; s.ready = rd;
        s.expCount = ec; s.expStall = es; s.expValid = ev;
        return s;
    endfunction

    task automatic checkVal(input string name, input int n, input logic [63:0] act,
                            input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s step %0d: got %0h expected %0h", name, n, act, exp);
        end
    endtask

    task automatic checkOutput(input step_t s, input int n);
        checkVal("count_o", n, 64'(countOut), 64'(s.expCount));
        checkVal("fu_stall_o", n, 64'(fuStall), 64'(s.expStall));
        checkVal("wb_valid_o", n, 64'(wbValid), 64'(s.expValid));
    endtask

    // Drive one cycle at the falling edge, retire/enqueue in the scoreboard, check after the edge.
    task automatic applyStimulus(input step_t s, input int n);
        bit      predFull;
        bit      predValid;
        sbItem_t exp;
        @(negedge clk);
        rstn       = s.rs;
        flushIn    = s.flush;
        fuDone     = s.done;
        fuRobIndex = s.idx;
        fuResult   = s.res;
        wbReady    = s.ready;
        predFull   = (sbQ.size() == DEPTH);
        predValid  = (sbQ.size() != 0);
        if (!s.rs || s.flush) begin
            sbQ.delete();
        end else begin
            if (predValid && s.ready) begin
                exp = sbQ.pop_front();
                checkVal("wb_rob_index_o", n, 64'(wbRobIndex), 64'(exp.idx));
                checkVal("wb_data_o", n, wbData, 64'(exp.res));
            end
            if (s.done && !predFull) sbQ.push_back({s.idx, s.res});
        end
        @(posedge clk);
        #1;
        checkOutput(s, n);
    endtask

    initial begin
        int n;
        rstn = 1'b0; flushIn = 1'b0; fuDone = 1'b0;
        fuRobIndex = '0; fuResult = 1'b0; wbReady = 1'b0;

        // reset
        steps.push_back(mk(0,0,0,0,0,0, 0,0,0));
        steps.push_back(mk(0,0,0,0,0,0, 0,0,0));
        // single pass
        steps.push_back(mk(1,0,1,5,1,1, 1,0,1));
        steps.push_back(mk(1,0,0,0,0,1, 0,0,0));
        // fill and back-pressure, FU holds index 5
        steps.push_back(mk(1,0,1,1,0,0, 1,0,1));
        steps.push_back(mk(1,0,1,2,1,0, 2,0,1));
        steps.push_back(mk(1,0,1,3,0,0, 3,0,1));
        steps.push_back(mk(1,0,1,4,1,0, 4,1,1));
        steps.push_back(mk(1,0,1,5,1,0, 4,1,1));
        steps.push_back(mk(1,0,1,5,1,0, 4,1,1));
        steps.push_back(mk(1,0,1,5,1,1, 3,0,1));
        steps.push_back(mk(1,0,1,5,1,1, 3,0,1));
        steps.push_back(mk(1,0,0,0,0,1, 2,0,1));
        steps.push_back(mk(1,0,0,0,0,1, 1,0,1));
        steps.push_back(mk(1,0,0,0,0,1, 0,0,0));
        // simultaneous enqueue/dequeue at count 2
        steps.push_back(mk(1,0,1,8,0,0, 1,0,1));
        steps.push_back(mk(1,0,1,9,1,0, 2,0,1));
        steps.push_back(mk(1,0,1,10,0,1, 2,0,1));
        steps.push_back(mk(1,0,0,0,0,1, 1,0,1));
        steps.push_back(mk(1,0,0,0,0,1, 0,0,0));
        // wrap-around streaming
        for (int i = 0; i < 10; i++) steps.push_back(mk(1,0,1,4'(i),i[0],1, 1,0,1));
        steps.push_back(mk(1,0,0,0,0,1, 0,0,0));
        // flush with concurrent enqueue and dequeue
        steps.push_back(mk(1,0,1,11,1,0, 1,0,1));
        steps.push_back(mk(1,0,1,12,0,0, 2,0,1));
        steps.push_back(mk(1,0,1,13,1,0, 3,0,1));
        steps.push_back(mk(1,1,1,7,1,1, 0,0,0));
        steps.push_back(mk(1,0,0,0,0,1, 0,0,0));
        // fill, then reset mid-operation
        steps.push_back(mk(1,0,1,1,1,0, 1,0,1));
        steps.push_back(mk(1,0,1,2,1,0, 2,0,1));
        steps.push_back(mk(1,0,1,3,1,0, 3,0,1));
        steps.push_back(mk(1,0,1,4,1,0, 4,1,1));
        steps.push_back(mk(0,0,1,6,1,1, 0,0,0));

        n = 0;
        foreach (steps[k]) begin
            applyStimulus(steps[k], n);
            n++;
        end

        checkVal("reset wb_data_o", n, wbData, 64'h0);
        checkVal("reset wb_rob_index_o", n, 64'(wbRobIndex), 64'h0);

        // head held stable while the arbiter is not ready
        applyStimulus(mk(1,0,0,0,0,0, 0,0,0), n++);
        applyStimulus(mk(1,0,1,14,1,0, 1,0,1), n++);
        applyStimulus(mk(1,0,1,3,0,0, 2,0,1), n++);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(mk(1,0,0,0,0,0, 2,0,1), n);
            checkVal("held wb_rob_index_o", n, 64'(wbRobIndex), 64'd14);
            checkVal("held wb_data_o", n, wbData, 64'h1);
            n++;
        end
        applyStimulus(mk(1,0,0,0,0,1, 1,0,1), n++);
        applyStimulus(mk(1,0,0,0,0,1, 0,0,0), n++);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmp_wb_buffer.md
Name: cmp_wb_buffer

Overview:
- Consumer end of the compare functional unit's completion interface.
- Accepts completed compare results (done, ROB index, 1-bit result) from the FU, buffers them in a small FIFO, and drives the ROB/regfile writeback port with a valid/ready handshake.
- Back-pressures the FU through its stall input when the buffer is full.
- Sits between the compare FU output register and the writeback arbiter.

Parameters:
- ROB_INDEX_WIDTH, 4, width of ROB index carried with each result.
- DEPTH, 4, number of buffer entries; power of two, minimum 2.
- XLEN, 64, width of writeback data bus.

Ports:
- clk  input  1  clock.
- rstn  input  1  reset, synchronous, active-low.
- flush_i  input  1  pipeline flush; discards all buffered results.
- fu_done_i  input  1  FU result valid.
- fu_rob_index_i  input  ROB_INDEX_WIDTH  ROB index of FU result.
- fu_result_i  input  1  FU compare result.
- fu_stall_o  output  1  stall to FU (acts as ~ready); FU holds its output while high.
- wb_valid_o  input/output: output  1  writeback entry valid.
- wb_ready_i  input  1  writeback arbiter accepts the entry.
- wb_rob_index_o  output  ROB_INDEX_WIDTH  ROB index of head entry.
- wb_data_o  output  XLEN  head result, zero-extended.
- count_o  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset, rstn low at posedge clk:
  - wr_ptr, rd_ptr and count are 0.
  - wb_valid_o=0, fu_stall_o=0, count_o=0.
  - wb_rob_index_o and wb_data_o are 0; entry storage need not be cleared.
- Enqueue: fire_in = fu_done_i && !fu_stall_o && !flush_i.
  - On fire_in, store {fu_rob_index_i, fu_result_i} at wr_ptr and increment wr_ptr (mod DEPTH).
- Dequeue: fire_out = wb_valid_o && wb_ready_i && !flush_i.
  - On fire_out, increment rd_ptr (mod DEPTH).
- count update: next count = count + fire_in - fire_out. Simultaneous enqueue and dequeue leaves count unchanged.
- Status signals:
  - fu_stall_o = (count == DEPTH).
  - It is a pure function of registered count, with no combinational path from wb_ready_i or fu_done_i.
  - When full, a same-cycle dequeue does not admit an enqueue; the FU result is accepted the following cycle.
- Held FU output: while fu_stall_o is high, the FU holds done/index/result unchanged. The buffer does not enqueue it until fu_stall_o drops, and then enqueues it exactly once.
- Writeback outputs:
  - wb_valid_o = (count != 0).
  - wb_rob_index_o and wb_data_o reflect the entry at rd_ptr.
  - wb_data_o = {(XLEN-1)'b0, result}.
  - While wb_valid_o is high and wb_ready_i is low, the outputs are held stable.
- Latency: a result accepted at edge t appears on wb_valid_o in the cycle after t. There is no bypass; minimum latency is 1 cycle.
- Ordering: strict FIFO; ROB indices leave in arrival order.
- Flush, synchronous:
  - Pointers and count go to 0, and wb_valid_o=0 next cycle.
  - An fu_done_i or wb_ready_i in the flush cycle is ignored; no entry is written or retired.
  - Flush has priority over enqueue and dequeue. Reset has priority over flush.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. count distinguishes full from empty.
- Reset mid-operation discards all entries, identical to the reset state.

Test Plan:
1. Single pass:
   - Stimulus: wb_ready_i=1; fu_done_i=1 for one cycle with index 5, result 1.
   - Required: next cycle wb_valid_o=1, wb_rob_index_o=5, wb_data_o=64'h1; the following cycle wb_valid_o=0 and count_o=0.
2. Fill and back-pressure:
   - Stimulus: wb_ready_i=0; 5 consecutive results with indices 1..5.
   - Required: entries 1..4 accepted; fu_stall_o=1 once count_o=4; the FU holds index 5.
   - Then raise wb_ready_i: index 1 retires, fu_stall_o drops next cycle, and index 5 is enqueued exactly once.
   - Output order is 1,2,3,4,5; no duplicate 5.
3. Simultaneous enqueue and dequeue at count_o=2:
   - Stimulus: fu_done_i=1 and wb_ready_i=1 in the same cycle.
   - Required: count_o stays 2; the head advances to the next index.
4. Wrap-around:
   - Stimulus: 10 results streamed with wb_ready_i=1 every cycle, indices 0..9.
   - Required: output sequence 0..9 in order; count_o never exceeds 1.
5. Flush:
   - Stimulus: buffer holding 3 entries; assert flush_i together with fu_done_i=1 (index 7) and wb_ready_i=1.
   - Required: next cycle count_o=0 and wb_valid_o=0; index 7 never appears; no entry counted as retired.
6. Reset mid-operation:
   - Stimulus: buffer full, fu_stall_o=1; drive rstn=0 for one cycle.
   - Required: count_o=0, fu_stall_o=0, wb_valid_o=0, wb_data_o=0 after the edge.
